score_digits_block: RTL and testbench
=====================================

// Module: score_digits_block
// PURPOSE
//  Keeps the current score and the high score as 4-digit BCD and draws both as digits on screen.
//  Score digits sit under the SCORE title; high-score digits sit under the HI-SCORE title.
//  Outputs scoreDigitsDR/scoreDigitsRGB to the top-level object mux, next to titlesDR/titlesRGB.
//  Points come from the hit-detection logic as 2-digit BCD pulses. Additions run serially, one digit per clock.
// PARAMETERS
//  SCORE_X      11'd30   top-left X of the score digit field
//  SCORE_Y      11'd30   top-left Y of the score digit field
//  HIGH_X       11'd408  top-left X of the high-score digit field
//  HIGH_Y       11'd30   top-left Y of the high-score digit field
//  DIGIT_COLOR  8'hFF    RGB332 value of lit digit pixels
//  Fixed, not parameters: 4 digits per field; each digit cell is 16x16 pixels; each field is 64x16.
// PORTS
//  clk            in   1   pixel clock
//  resetN         in   1   asynchronous, active-low reset
//  startOfFrame   in   1   one-cycle pulse at frame start
//  gameEnded      in   1   level, high while the game-over screen shows
//  standBy        in   1   level, high in attract/standby mode
//  pointsValid    in   1   one-cycle pulse: add pointsBCD to the score
//  pointsBCD      in   8   two BCD digits, 00..99
//  pixelX         in   11  current pixel X
//  pixelY         in   11  current pixel Y
//  addBusy        out  1   high while a serial addition is in progress
//  pointsLost     out  1   sticky flag: a points pulse was dropped
//  scoreDigitsDR  out  1   drawing request, registered
//  scoreDigitsRGB out  8   pixel colour, registered
// BEHAVIOUR
//  Reset values: every register, every output, score, high and both display latches = 0. Reset is asynchronous and overrides any operation in progress.
//  playGame = ~(gameEnded | standBy).
//  Clear: when playGame rises (registered edge detect), score <= 0000 on the next cycle.
//    Clear also aborts any running addition and empties the pending slot.
//    A pointsValid in the same cycle as the clear is dropped; pointsLost is not set.
//  Points accepted only while playGame = 1; pulses at other times are ignored.
//  Input digits > 9 are clamped to 9.
//  Add FSM states: IDLE, D0, D1, D2, D3.
//    IDLE: on pointsValid, latch the operand (or the pending slot if full); go to D0.
//    Dn: score digit n <= (digit n + operand digit n + carry) mod 10; carry <= sum > 9.
//      Operand digits 2 and 3 are 0.
//    D3 -> IDLE. If a carry leaves digit 3, score saturates to 9999.
//    addBusy = (state != IDLE). An addition takes 4 cycles after the accept cycle.
//  Pending slot: one entry.
//    A pointsValid while busy is stored in the slot and consumed in the cycle the FSM returns to IDLE (no idle bubble).
//    A pointsValid while busy and the slot is full is dropped and sets pointsLost.
//    pointsLost is cleared only by reset.
//  High score: on the rising edge of gameEnded, if score > high then high <= score.
//    Compare the 16-bit BCD values as unsigned; ordering is preserved.
//    If an addition is still running, the update waits until the FSM reaches IDLE.
//  Display latches: scoreShown <= score and highShown <= high on startOfFrame only. This prevents mid-frame tearing.
//  Render:
//    Inside a field: dx = pixelX - fieldX, digit index = dx[5:4] (0 = most significant), row = pixelY - fieldY, column = dx[3:0].
//    Leading zeros are drawn.
//    Lit pixel: next cycle DR = 1, RGB = DIGIT_COLOR.
//    Otherwise: DR = 0, RGB = 8'h00.
//    Latency: exactly 1 clock from pixelX/pixelY to DR/RGB.
//  Field bounds: inclusive at the top-left corner, exclusive at +64 in X and +16 in Y.
// STRUCTURE
//  Shared package score_pkg:
//    typedef logic [3:0] bcd_digit_t;
//    typedef logic [15:0] bcd4_t;
//    add-FSM state enum;
//    constants DIGIT_W = 16, DIGIT_H = 16, NUM_DIGITS = 4.
//  Sub-module digit_bitmap: combinational 1-bit font ROM, 10 glyphs x 16x16. Inputs: digit, row, column. Output: lit.
//  The top level holds the add FSM, the high-score compare, the latches and the output register.
// TESTING
//  1. Reset; playGame = 1; pointsBCD = 8'h30 pulse -> addBusy high for 4 cycles; score = 0030. After the next startOfFrame, digit field pixels show "0030".
//  2. score = 0095; add 8'h10 -> score = 0105, carry ripples through D1 and D2.
//  3. Saturation: score = 9990; add 8'h20 -> score = 9999.
//  4. Back-to-back pulses 10, 20, 30 during one busy window:
//     - 20 is queued; 30 is dropped and pointsLost = 1; final score = +30.
//     - A 10 then 20 pair -> +30, and the second add starts with no idle cycle.
//  5. gameEnded rises with score 0450 and high 0300 -> high = 0450. A later game with 0200 -> high stays 0450.
//     standBy falls -> score = 0000.
//  6. Render check: pixel (SCORE_X+16, SCORE_Y) -> DR one cycle later matches glyph row 0 of digit 1.
//     Pixel (SCORE_X+64, SCORE_Y) -> DR = 0.
//     Assert resetN low mid-add -> all outputs 0 immediately.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and constants for the score / high-score digit display.
// Includes the 7-segment code table used by the digit font.
package score_pkg;

  typedef logic [3:0]  bcd_digit_t;
  typedef logic [15:0] bcd4_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_D0,
    S_D1,
    S_D2,
    S_D3
  } add_state_t;

  localparam int DIGIT_W    = 16;
  localparam int DIGIT_H    = 16;
  localparam int NUM_DIGITS = 4;

  function automatic bcd_digit_t clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Segment bits ordered {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_code(input bcd_digit_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/score_digits_block_digit_bitmap.sv
// 16x16 digit font: segment-style glyphs for 0..9.
// Bars are two pixels thick with a two-pixel side margin.
module digit_bitmap
  import score_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic [3:0] row,
  input  logic [3:0] column,
  output logic       lit
);

  logic [6:0] w_seg;
  logic       w_hbar;
  logic       w_lcol;
  logic       w_rcol;
  logic       w_top;
  logic       w_bot;

  assign w_seg  = seg_code(digit);
  assign w_hbar = (column >= 4'd2) && (column <= 4'd13);
  assign w_lcol = (column == 4'd2) || (column == 4'd3);
  assign w_rcol = (column == 4'd12) || (column == 4'd13);
  assign w_top  = (row <= 4'd7);
  assign w_bot  = (row >= 4'd8);

  assign lit = (w_seg[0] & w_hbar & (row <= 4'd1))
             | (w_seg[1] & w_rcol & w_top)
             | (w_seg[2] & w_rcol & w_bot)
             | (w_seg[3] & w_hbar & (row >= 4'd14))
             | (w_seg[4] & w_lcol & w_bot)
             | (w_seg[5] & w_lcol & w_top)
             | (w_seg[6] & w_hbar & ((row == 4'd7) | (row == 4'd8)));

endmodule

// File: rtl/score_digits_block.sv
// Score / high-score keeper with serial BCD adder and digit renderer.
// Output pixel is registered: one clock from pixelX/pixelY to DR/RGB.
module score_digits_block
  import score_pkg::*;
#(
  parameter logic [10:0] SCORE_X     = 11'd30,
  parameter logic [10:0] SCORE_Y     = 11'd30,
  parameter logic [10:0] HIGH_X      = 11'd408,
  parameter logic [10:0] HIGH_Y      = 11'd30,
  parameter logic [7:0]  DIGIT_COLOR = 8'hFF
)(
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        gameEnded,
  input  logic        standBy,
  input  logic        pointsValid,
  input  logic [7:0]  pointsBCD,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic        addBusy,
  output logic        pointsLost,
  output logic        scoreDigitsDR,
  output logic [7:0]  scoreDigitsRGB
);

  localparam logic [10:0] FIELD_W = 11'(NUM_DIGITS * DIGIT_W);
  localparam logic [10:0] FIELD_H = 11'(DIGIT_H);

  add_state_t r_state;
  bcd4_t      r_score;
  bcd4_t      r_high;
  bcd4_t      r_score_sh;
  bcd4_t      r_high_sh;
  logic [7:0] r_op;
  logic [7:0] r_pend;
  logic       r_pend_v;
  logic       r_carry;
  logic       r_play;
  logic       r_ge;
  logic       r_hs_req;
  logic       r_lost;
  logic       r_dr;
  logic [7:0] r_rgb;

  logic       w_play;
  logic       w_clear;
  logic       w_pv;
  logic       w_hs_pend;
  logic [7:0] w_pts;
  logic [1:0] w_n;
  bcd_digit_t w_sd;
  bcd_digit_t w_od;
  bcd_digit_t w_dig;
  logic [4:0] w_sum;
  logic       w_cout;

  assign w_play    = ~(gameEnded | standBy);
  assign w_clear   = w_play & ~r_play;
  assign w_pv      = pointsValid & w_play & ~w_clear;
  assign w_pts     = {clamp_bcd(pointsBCD[7:4]), clamp_bcd(pointsBCD[3:0])};
  assign w_hs_pend = r_hs_req | (gameEnded & ~r_ge);

  always_comb begin
    w_n = 2'd0;
    unique case (r_state)
      S_D1:    w_n = 2'd1;
      S_D2:    w_n = 2'd2;
      S_D3:    w_n = 2'd3;
      default: w_n = 2'd0;
    endcase
    w_sd   = r_score[{w_n, 2'b00} +: 4];
    w_od   = (w_n == 2'd0) ? r_op[3:0] :
             (w_n == 2'd1) ? r_op[7:4] : 4'd0;
    w_sum  = {1'b0, w_sd} + {1'b0, w_od} + {4'd0, r_carry};
    w_cout = (w_sum > 5'd9);
    w_dig  = w_cout ? (w_sum[3:0] - 4'd10) : w_sum[3:0];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= S_IDLE;
      r_score  <= '0;
      r_op     <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_carry  <= 1'b0;
      r_lost   <= 1'b0;
      r_play   <= 1'b0;
    end else begin
      r_play <= w_play;
      if (w_clear) begin
        r_state  <= S_IDLE;
        r_score  <= '0;
        r_pend_v <= 1'b0;
        r_carry  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_pv) begin
              r_op    <= w_pts;
              r_carry <= 1'b0;
              r_state <= S_D0;
            end
          end
          S_D3: begin
            if (w_cout) r_score <= 16'h9999;
            else        r_score[15:12] <= w_dig;
            r_carry <= 1'b0;
            // Chain straight into the next add so there is no idle bubble
            if (r_pend_v) begin
              r_op     <= r_pend;
              r_state  <= S_D0;
              r_pend_v <= w_pv;
              if (w_pv) r_pend <= w_pts;
            end else if (w_pv) begin
              r_op    <= w_pts;
              r_state <= S_D0;
            end else begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_score[{w_n, 2'b00} +: 4] <= w_dig;
            r_carry <= w_cout;
            r_state <= (r_state == S_D0) ? S_D1 :
                       (r_state == S_D1) ? S_D2 : S_D3;
            if (w_pv && !r_pend_v) begin
              r_pend   <= w_pts;
              r_pend_v <= 1'b1;
            end
            if (w_pv && r_pend_v) r_lost <= 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_ge       <= 1'b0;
      r_hs_req   <= 1'b0;
      r_high     <= '0;
      r_score_sh <= '0;
      r_high_sh  <= '0;
    end else begin
      r_ge <= gameEnded;
      if (w_hs_pend && r_state == S_IDLE) begin
        if (r_score > r_high) r_high <= r_score;
        r_hs_req <= 1'b0;
      end else begin
        r_hs_req <= w_hs_pend;
      end
      if (startOfFrame) begin
        r_score_sh <= r_score;
        r_high_sh  <= r_high;
      end
    end
  end

  logic [10:0] w_sdx;
  logic [10:0] w_sdy;
  logic [10:0] w_hdx;
  logic [10:0] w_hdy;
  logic        w_in_s;
  logic        w_in_h;
  logic [5:0]  w_dx;
  logic [3:0]  w_row;
  bcd4_t       w_shown;
  bcd_digit_t  w_glyph;
  logic        w_lit;

  assign w_sdx  = pixelX - SCORE_X;
  assign w_sdy  = pixelY - SCORE_Y;
  assign w_hdx  = pixelX - HIGH_X;
  assign w_hdy  = pixelY - HIGH_Y;
  assign w_in_s = (pixelX >= SCORE_X) && (w_sdx < FIELD_W)
               && (pixelY >= SCORE_Y) && (w_sdy < FIELD_H);
  assign w_in_h = (pixelX >= HIGH_X) && (w_hdx < FIELD_W)
               && (pixelY >= HIGH_Y) && (w_hdy < FIELD_H);

  assign w_dx    = w_in_s ? w_sdx[5:0] : w_hdx[5:0];
  assign w_row   = w_in_s ? w_sdy[3:0] : w_hdy[3:0];
  assign w_shown = w_in_s ? r_score_sh : r_high_sh;
  // Digit index 0 is the most significant nibble
  assign w_glyph = w_shown[{~w_dx[5:4], 2'b00} +: 4];

  digit_bitmap u_font (
    .digit  (w_glyph),
    .row    (w_row),
    .column (w_dx[3:0]),
    .lit    (w_lit)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_dr  <= 1'b0;
      r_rgb <= 8'h00;
    end else begin
      r_dr  <= (w_in_s | w_in_h) & w_lit;
      r_rgb <= ((w_in_s | w_in_h) & w_lit) ? DIGIT_COLOR : 8'h00;
    end
  end

  assign addBusy        = (r_state != S_IDLE);
  assign pointsLost     = r_lost;
  assign scoreDigitsDR  = r_dr;
  assign scoreDigitsRGB = r_rgb;

endmodule

// File: tb/tb_score_digits_block.sv
// Directed bench for score_digits_block: scoring, queueing, high score,
// saturation, rendering bounds and asynchronous reset.
module tb_score_digits_block;

  localparam logic [10:0] SX = 11'd30;
  localparam logic [10:0] SY = 11'd30;
  localparam logic [10:0] HX = 11'd408;
  localparam logic [10:0] HY = 11'd30;

  // Standard 7-seg codes {g,f,e,d,c,b,a} and one probe pixel per segment
  localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam int PR [7] = '{0, 4, 11, 15, 11, 4, 7};
  localparam int PC [7] = '{7, 13, 13, 7, 2, 2, 7};

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        gameEnded = 1'b0;
  logic        standBy = 1'b1;
  logic        pointsValid = 1'b0;
  logic [7:0]  pointsBCD = 8'h00;
  logic [10:0] pixelX = 11'd0;
  logic [10:0] pixelY = 11'd0;
  logic        addBusy;
  logic        pointsLost;
  logic        scoreDigitsDR;
  logic [7:0]  scoreDigitsRGB;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  score_digits_block dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .gameEnded      (gameEnded),
    .standBy        (standBy),
    .pointsValid    (pointsValid),
    .pointsBCD      (pointsBCD),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .addBusy        (addBusy),
    .pointsLost     (pointsLost),
    .scoreDigitsDR  (scoreDigitsDR),
    .scoreDigitsRGB (scoreDigitsRGB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (!addBusy) break;
      tick();
    end
    chk(tag, 32'(addBusy), 32'd0);
  endtask

  task automatic add(input logic [7:0] p);
    pointsValid = 1'b1;
    pointsBCD = p;
    tick();
    pointsValid = 1'b0;
    wait_idle("add_timeout");
  endtask

  task automatic new_game();
    standBy = 1'b1;
    tick();
    standBy = 1'b0;
    tick();
  endtask

  task automatic probe(input logic [10:0] x, input logic [10:0] y,
                       output logic dr, output logic [7:0] rgb);
    pixelX = x;
    pixelY = y;
    tick();
    dr = scoreDigitsDR;
    rgb = scoreDigitsRGB;
  endtask

  task automatic show(input string tag, input logic [10:0] fx,
                      input logic [10:0] fy, input logic [15:0] val);
    logic [27:0] obs;
    logic [27:0] exp;
    logic [3:0]  d;
    logic [6:0]  seg;
    logic        dr;
    logic [7:0]  rgb;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = val[15-4*i -: 4];
      seg = SEG[d];
      for (int s = 0; s < 7; s++) begin
        probe(fx + 11'(16 * i + PC[s]), fy + 11'(PR[s]), dr, rgb);
        obs[i*7+s] = dr;
        exp[i*7+s] = seg[s];
      end
    end
    chk(tag, 32'(obs), 32'(exp));
  endtask

  // Counts busy samples over a window and flags any busy->idle->busy gap
  task automatic busy_window(input string tag, input int exp_cnt);
    int cnt;
    logic seen_low;
    logic gap;
    cnt = 0;
    seen_low = 1'b0;
    gap = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (addBusy) begin
        cnt++;
        if (seen_low) gap = 1'b1;
      end else begin
        seen_low = 1'b1;
      end
      tick();
    end
    chk(tag, {gap, 31'(cnt)}, 32'(exp_cnt));
  endtask

  initial begin
    logic       dr;
    logic [7:0] rgb;

    #2 resetN = 1'b0;
    tick();
    tick();
    chk("reset_outputs", {pointsLost, addBusy, scoreDigitsDR, scoreDigitsRGB},
        32'd0);
    resetN = 1'b1;
    tick();
    standBy = 1'b0;
    tick();

    // 1: add 30, four busy cycles
    pointsValid = 1'b1;
    pointsBCD = 8'h30;
    tick();
    pointsValid = 1'b0;
    busy_window("busy_4_cycles", 4);
    show("score_0030", SX, SY, 16'h0030);

    // 2: ripple carry
    add(8'h65);
    show("score_0095", SX, SY, 16'h0095);
    add(8'h10);
    show("score_0105", SX, SY, 16'h0105);
    add(8'hA3);
    show("clamp_0198", SX, SY, 16'h0198);

    // 5: high score
    new_game();
    add(8'h99); add(8'h99); add(8'h99); add(8'h03);
    gameEnded = 1'b1;
    tick(); tick();
    show("high_0300", HX, HY, 16'h0300);
    gameEnded = 1'b0;
    tick();
    add(8'h99); add(8'h99); add(8'h99); add(8'h99);
    pointsValid = 1'b1;
    pointsBCD = 8'h54;
    tick();
    pointsValid = 1'b0;
    gameEnded = 1'b1;
    tick();
    wait_idle("hs_add_timeout");
    tick();
    show("high_0450_wait", HX, HY, 16'h0450);
    show("score_0450", SX, SY, 16'h0450);
    gameEnded = 1'b0;
    tick();
    add(8'h99); add(8'h99); add(8'h02);
    gameEnded = 1'b1;
    tick(); tick();
    show("high_stays_0450", HX, HY, 16'h0450);
    show("score_0200", SX, SY, 16'h0200);
    standBy = 1'b1;
    tick();
    gameEnded = 1'b0;
    tick();
    pointsValid = 1'b1;
    pointsBCD = 8'h50;
    tick();
    pointsValid = 1'b0;
    chk("ignore_standby", 32'(addBusy), 32'd0);
    show("score_kept_0200", SX, SY, 16'h0200);
    standBy = 1'b0;
    tick();
    show("standby_clear", SX, SY, 16'h0000);

    // Clear aborts an add, empties the slot and drops a same-cycle pulse
    pointsValid = 1'b1;
    pointsBCD = 8'h99;
    tick();
    pointsBCD = 8'h22;
    tick();
    pointsValid = 1'b0;
    standBy = 1'b1;
    tick();
    standBy = 1'b0;
    pointsValid = 1'b1;
    pointsBCD = 8'h11;
    tick();
    pointsValid = 1'b0;
    chk("clear_aborts", 32'(addBusy), 32'd0);
    tick();
    pointsValid = 1'b1;
    pointsBCD = 8'h05;
    tick();
    pointsBCD = 8'h07;
    tick();
    pointsValid = 1'b0;
    wait_idle("post_clear_timeout");
    chk("lost_after_clear", 32'(pointsLost), 32'd0);
    show("score_0012", SX, SY, 16'h0012);

    // 3: saturation
    new_game();
    for (int k = 0; k < 100; k++) add(8'h99);
    add(8'h90);
    show("score_9990", SX, SY, 16'h9990);
    add(8'h20);
    show("saturate_9999", SX, SY, 16'h9999);

    // 4: queue and drop
    new_game();
    pointsValid = 1'b1;
    pointsBCD = 8'h10;
    tick();
    pointsBCD = 8'h20;
    tick();
    pointsBCD = 8'h30;
    tick();
    pointsValid = 1'b0;
    chk("lost_set", 32'(pointsLost), 32'd1);
    wait_idle("queue_timeout");
    show("queued_0030", SX, SY, 16'h0030);
    pointsValid = 1'b1;
    pointsBCD = 8'h10;
    tick();
    pointsBCD = 8'h20;
    tick();
    pointsValid = 1'b0;
    busy_window("no_bubble", 7);
    show("pair_0060", SX, SY, 16'h0060);
    chk("lost_sticky", 32'(pointsLost), 32'd1);

    // 6: render bounds and latency on "0060"
    probe(SX + 11'd23, SY, dr, rgb);
    chk("d1_row0_lit", {dr, rgb}, {1'b1, 8'hFF});
    probe(SX + 11'd16, SY, dr, rgb);
    chk("d1_col0_dark", {dr, rgb}, 9'd0);
    probe(SX + 11'd2, SY, dr, rgb);
    chk("topleft_incl", 32'(dr), 32'd1);
    probe(SX + 11'd71, SY, dr, rgb);
    chk("right_excl", {dr, rgb}, 9'd0);
    probe(SX + 11'd7, SY + 11'd16, dr, rgb);
    chk("bottom_excl", 32'(dr), 32'd0);
    probe(SX - 11'd9, SY, dr, rgb);
    chk("left_out", 32'(dr), 32'd0);
    pixelX = SX + 11'd7;
    pixelY = SY;
    #1;
    chk("latency_before", 32'(scoreDigitsDR), 32'd0);
    tick();
    chk("latency_after", 32'(scoreDigitsDR), 32'd1);

    // Asynchronous reset mid-add
    pointsValid = 1'b1;
    pointsBCD = 8'h10;
    tick();
    pointsValid = 1'b0;
    chk("pre_reset", {addBusy, pointsLost, scoreDigitsDR}, 3'b111);
    #2 resetN = 1'b0;
    #1;
    chk("async_reset", {addBusy, pointsLost, scoreDigitsDR, scoreDigitsRGB},
        32'd0);
    tick();
    resetN = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
